mm_ctrl: RTL and testbench

- Sequencing controller for the MM matrix-multiply block.
- Parses the serial element stream framing (col_end/row_end) for matrix A, then matrix B, and generates write addresses into the A/B element buffers.
- Checks shape legality, then scans every output element, driving buffer read addresses and accumulator clear/enable to the MAC datapath.
- Drives busy, valid, is_legal and change_row at the MM top level; in_data and out_data stay in the datapath.

---
 rtl/mm_pkg.sv | 21 ++
 rtl/mm_if.sv | 19 +
 rtl/mm_shape_tracker.sv | 74 +++++++
 rtl/mm_ctrl.sv | 143 ++++++++++++++
 tb/tb_mm_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared constants, FSM states and shape record for the MM sequencing controller.
package mm_pkg;
  localparam int MAX_DIM = 4;
  localparam int IW      = $clog2(MAX_DIM);
  localparam int CW      = IW + 1;
  localparam int AW      = 2 * IW;

  typedef enum logic [3:0] {
    LOAD_A, LOAD_B, CHECK, ILL_WAIT, ILLEGAL, CLR, MAC, DRAIN, EMIT, GAP
  } state_e;

  typedef struct packed {
    logic [CW-1:0] rows;
    logic [CW-1:0] cols;
  } dims_t;

  // True when idx is the last index of a dimension of size dim.
  function automatic logic is_last(logic [IW-1:0] idx, logic [CW-1:0] dim);
    return {1'b0, idx} == (dim - CW'(1));
  endfunction
endpackage

// File: rtl/mm_if.sv
// Stream-in / buffer-control / result-strobe bundle between MM top and its controller.
interface mm_if;
  import mm_pkg::*;
  logic          in_valid, col_end, row_end;
  logic          busy, we_a, we_b;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic          acc_clr, acc_en, valid, is_legal, change_row;

  modport master (
    output in_valid, col_end, row_end,
    input  busy, we_a, we_b, wr_addr, rd_addr_a, rd_addr_b,
    input  acc_clr, acc_en, valid, is_legal, change_row
  );
  modport slave (
    input  in_valid, col_end, row_end,
    output busy, we_a, we_b, wr_addr, rd_addr_a, rd_addr_b,
    output acc_clr, acc_en, valid, is_legal, change_row
  );
endinterface

// File: rtl/mm_shape_tracker.sv
// Row/column counters for one incoming matrix; captures its shape and flags overflow.
module mm_shape_tracker import mm_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          acc_i,
  input  logic          col_end_i,
  input  logic          row_end_i,
  output logic [IW-1:0] row_o,
  output logic [IW-1:0] col_o,
  output dims_t         dims_o,
  output logic          ovf_o,
  output dims_t         dims_upd_o,
  output logic          ovf_upd_o
);
  logic [IW-1:0] row_q, row_d, col_q, col_d, row_u, col_u;
  dims_t         dims_q, dims_d;
  logic          ovf_q, ovf_d;
  logic          last_col;

  // row_end alone closes the row as well as the matrix
  assign last_col = col_end_i | row_end_i;

  always_comb begin
    row_u      = row_q;
    col_u      = col_q;
    dims_upd_o = dims_q;
    ovf_upd_o  = ovf_q;
    if (acc_i) begin
      if (last_col) begin
        col_u = '0;
        if (row_q == '0) dims_upd_o.cols = CW'(col_q) + CW'(1);
        if (row_end_i) begin
          dims_upd_o.rows = CW'(row_q) + CW'(1);
          row_u           = '0;
        end else begin
          row_u = row_q + IW'(1);
          if (row_q == IW'(MAX_DIM-1)) ovf_upd_o = 1'b1;
        end
      end else begin
        col_u = col_q + IW'(1);
        if (col_q == IW'(MAX_DIM-1)) ovf_upd_o = 1'b1;
      end
    end
  end

  // Update values stay visible on *_upd_o even when clr_i wipes the registers,
  // so the owner can latch the final shape on the same edge.
  always_comb begin
    row_d  = clr_i ? '0 : row_u;
    col_d  = clr_i ? '0 : col_u;
    dims_d = clr_i ? '0 : dims_upd_o;
    ovf_d  = clr_i ? 1'b0 : ovf_upd_o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      dims_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      dims_q <= dims_d;
      ovf_q  <= ovf_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign dims_o = dims_q;
  assign ovf_o  = ovf_q;
endmodule

// File: rtl/mm_ctrl.sv
// MM sequencing controller: loads A then B shapes, checks legality, then walks
// every output element driving buffer reads and accumulator control.
module mm_ctrl import mm_pkg::*; (
  input logic clk,
  input logic rst,
  mm_if.slave bus
);
  state_e        state_q, state_d;
  dims_t         a_dims_q, a_dims_d;
  logic          ovf_a_q, ovf_a_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

  logic          loading, accept, trk_clr, trk_ovf, trk_ovf_upd;
  logic [IW-1:0] trk_row, trk_col;
  dims_t         b_dims, trk_dims_upd;
  logic          legal, k_last, j_last, i_last;
  logic          acc_clr, acc_en, valid, is_legal, change_row;

  assign loading = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign accept  = bus.in_valid && loading;

  mm_shape_tracker u_trk (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (trk_clr),
    .acc_i      (accept),
    .col_end_i  (bus.col_end),
    .row_end_i  (bus.row_end),
    .row_o      (trk_row),
    .col_o      (trk_col),
    .dims_o     (b_dims),
    .ovf_o      (trk_ovf),
    .dims_upd_o (trk_dims_upd),
    .ovf_upd_o  (trk_ovf_upd)
  );

  assign legal  = (a_dims_q.cols == b_dims.rows) && !ovf_a_q && !trk_ovf;
  assign k_last = is_last(k_q, a_dims_q.cols);
  assign j_last = is_last(j_q, b_dims.cols);
  assign i_last = is_last(i_q, a_dims_q.rows);

  always_comb begin
    state_d    = state_q;
    a_dims_d   = a_dims_q;
    ovf_a_d    = ovf_a_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    trk_clr    = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    valid      = 1'b0;
    is_legal   = 1'b1;
    change_row = 1'b0;
    case (state_q)
      LOAD_A: if (accept && bus.row_end) begin
        // tracker is reused for B, so A's shape is latched here
        a_dims_d = trk_dims_upd;
        ovf_a_d  = trk_ovf_upd;
        trk_clr  = 1'b1;
        state_d  = LOAD_B;
      end
      LOAD_B: if (accept && bus.row_end) state_d = CHECK;
      CHECK: begin
        i_d     = '0;
        j_d     = '0;
        state_d = legal ? CLR : ILL_WAIT;
      end
      ILL_WAIT: state_d = ILLEGAL;
      ILLEGAL: begin
        valid    = 1'b1;
        is_legal = 1'b0;
        trk_clr  = 1'b1;
        state_d  = LOAD_A;
      end
      CLR: begin
        acc_clr = 1'b1;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        // read data lags the address by one cycle
        acc_en = (k_q != '0);
        k_d    = k_q + IW'(1);
        if (k_last) state_d = DRAIN;
      end
      DRAIN: begin
        acc_en  = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        valid      = 1'b1;
        change_row = j_last;
        state_d    = GAP;
      end
      GAP: begin
        state_d = CLR;
        if (j_last) begin
          j_d = '0;
          if (i_last) begin
            trk_clr = 1'b1;
            state_d = LOAD_A;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD_A;
      a_dims_q <= '0;
      ovf_a_q  <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      a_dims_q <= a_dims_d;
      ovf_a_q  <= ovf_a_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
    end
  end

  assign bus.busy       = !loading;
  assign bus.we_a       = accept && (state_q == LOAD_A) && !trk_ovf;
  assign bus.we_b       = accept && (state_q == LOAD_B) && !trk_ovf && !ovf_a_q;
  assign bus.wr_addr    = {trk_row, trk_col};
  assign bus.rd_addr_a  = {i_q, k_q};
  assign bus.rd_addr_b  = {k_q, j_q};
  assign bus.acc_clr    = acc_clr;
  assign bus.acc_en     = acc_en;
  assign bus.valid      = valid;
  assign bus.is_legal   = is_legal;
  assign bus.change_row = change_row;
endmodule

// File: tb/tb_mm_ctrl.sv
// Directed bench for mm_ctrl: load-phase vector table plus multi-cycle sequences.
module tb_mm_ctrl;
  import mm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mm_if bus();
  mm_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic          iv, ce, re;
    logic          we_a, we_b;
    logic [AW-1:0] addr;
    logic          busy;
  } vec_t;

  int            n_vec = 0, n_err = 0;
  int            nval, nacc, done_cyc, nwa;
  int            vcyc[8];
  logic          vcr[8], vleg[8];
  logic          ae[128], ac[128];
  logic [AW-1:0] ra[128], rb[128];
  logic [AW-1:0] wa[32];
  vec_t          tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.col_end  = 1'b0;
    bus.row_end  = 1'b0;
  endtask

  // Streams a rows x cols matrix; optional idle gap after element gap_at,
  // with stray col_end held high to confirm it is ignored without in_valid.
  task automatic load(input int rows, input int cols, input int gap_at, input int gap_len);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        bus.in_valid = 1'b1;
        bus.col_end  = (c == cols-1);
        bus.row_end  = (r == rows-1) && (c == cols-1);
        #1;
        if ((bus.we_a || bus.we_b) && nwa < 32) begin
          wa[nwa] = bus.wr_addr;
          nwa++;
        end
        tick();
        if (r*cols + c == gap_at)
          for (int g = 0; g < gap_len; g++) begin
            bus.in_valid = 1'b0;
            bus.col_end  = 1'b1;
            bus.row_end  = 1'b0;
            tick();
          end
      end
    idle();
  endtask

  // Records per-cycle activity until busy drops (bounded).
  task automatic collect(input int start);
    nval = 0; nacc = 0; done_cyc = -1;
    for (int c = 0; c < 128; c++) begin
      ae[c] = 1'b0; ac[c] = 1'b0; ra[c] = '0; rb[c] = '0;
    end
    for (int cyc = start; cyc < 100; cyc++) begin
      if (!bus.busy) begin
        done_cyc = cyc;
        break;
      end
      if (bus.valid && nval < 8) begin
        vcyc[nval] = cyc;
        vcr[nval]  = bus.change_row;
        vleg[nval] = bus.is_legal;
        nval++;
      end
      ae[cyc] = bus.acc_en;
      ac[cyc] = bus.acc_clr;
      ra[cyc] = bus.rd_addr_a;
      rb[cyc] = bus.rd_addr_b;
      if (bus.acc_en) nacc++;
      tick();
    end
  endtask

  task automatic check_2x2(input string tag);
    chk({tag, "_nwa"}, nwa, 8);
    for (int n = 0; n < 8; n++)
      chk({tag, "_wr_addr"}, wa[n], (n%4 < 2) ? n%2 : 4 + n%2);
    chk({tag, "_nval"}, nval, 4);
    for (int n = 0; n < 4; n++) begin
      chk({tag, "_vcyc"}, vcyc[n], 6 + 6*n);
      chk({tag, "_crow"}, vcr[n], n%2);
      chk({tag, "_legal"}, vleg[n], 1);
    end
    chk({tag, "_nacc"}, nacc, 8);
    chk({tag, "_done"}, done_cyc, 26);
  endtask

  initial begin
    idle();
    tbl[0]  = '{1,0,0, 1,0, 4'd0, 0};
    tbl[1]  = '{1,0,0, 1,0, 4'd1, 0};
    tbl[2]  = '{1,1,0, 1,0, 4'd2, 0};
    tbl[3]  = '{1,0,0, 1,0, 4'd4, 0};
    tbl[4]  = '{1,0,0, 1,0, 4'd5, 0};
    tbl[5]  = '{1,1,1, 1,0, 4'd6, 0};
    tbl[6]  = '{1,0,0, 0,1, 4'd0, 0};
    tbl[7]  = '{1,1,0, 0,1, 4'd1, 0};
    tbl[8]  = '{1,0,0, 0,1, 4'd4, 0};
    tbl[9]  = '{1,1,0, 0,1, 4'd5, 0};
    tbl[10] = '{1,0,0, 0,1, 4'd8, 0};
    tbl[11] = '{1,1,1, 0,1, 4'd9, 0};
    tbl[12] = '{0,0,0, 0,0, 4'd0, 1};

    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_is_legal", bus.is_legal, 1);
    chk("rst_acc_en", bus.acc_en, 0);
    chk("rst_acc_clr", bus.acc_clr, 0);
    chk("rst_change_row", bus.change_row, 0);
    chk("rst_we_a", bus.we_a, 0);
    rst = 1'b0;
    tick();

    // 2x3 * 3x2 through the vector table
    for (int v = 0; v < 13; v++) begin
      bus.in_valid = tbl[v].iv;
      bus.col_end  = tbl[v].ce;
      bus.row_end  = tbl[v].re;
      #1;
      chk("tbl_we_a", bus.we_a, tbl[v].we_a);
      chk("tbl_we_b", bus.we_b, tbl[v].we_b);
      chk("tbl_busy", bus.busy, tbl[v].busy);
      if (tbl[v].we_a || tbl[v].we_b) chk("tbl_wr_addr", bus.wr_addr, tbl[v].addr);
      tick();
    end
    idle();
    collect(2);
    chk("m23_nval", nval, 4);
    for (int n = 0; n < 4; n++) begin
      chk("m23_vcyc", vcyc[n], 7 + 7*n);
      chk("m23_crow", vcr[n], n%2);
      chk("m23_legal", vleg[n], 1);
    end
    for (int k = 0; k < 3; k++) begin
      chk("m23_rd_a", ra[3+k], k);
      chk("m23_rd_b", rb[3+k], 4*k);
    end
    chk("m23_clr", ac[2], 1);
    chk("m23_acc_first", ae[3], 0);
    chk("m23_acc_second", ae[4], 1);
    chk("m23_acc_drain", ae[6], 1);
    chk("m23_nacc", nacc, 12);
    chk("m23_done", done_cyc, 30);

    // 2x3 * 2x2: shape mismatch
    nwa = 0;
    load(2, 3, -1, 0);
    load(2, 2, -1, 0);
    collect(1);
    chk("ill_nval", nval, 1);
    chk("ill_vcyc", vcyc[0], 3);
    chk("ill_legal", vleg[0], 0);
    chk("ill_crow", vcr[0], 0);
    chk("ill_nacc", nacc, 0);
    chk("ill_done", done_cyc, 4);

    // 1x1 * 1x1
    load(1, 1, -1, 0);
    load(1, 1, -1, 0);
    collect(1);
    chk("m11_nval", nval, 1);
    chk("m11_vcyc", vcyc[0], 5);
    chk("m11_crow", vcr[0], 1);
    chk("m11_legal", vleg[0], 1);
    chk("m11_drain", ae[4], 1);
    chk("m11_nacc", nacc, 1);
    chk("m11_done", done_cyc, 7);

    // A is 1x5: column overflow
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.col_end  = (c == 4);
      bus.row_end  = (c == 4);
      #1;
      chk("ovf_we_a", bus.we_a, (c < 4));
      tick();
    end
    idle();
    load(1, 1, -1, 0);
    collect(1);
    chk("ovf_nval", nval, 1);
    chk("ovf_vcyc", vcyc[0], 3);
    chk("ovf_legal", vleg[0], 0);
    chk("ovf_nacc", nacc, 0);

    // 2x2 * 2x2 without and with input gaps
    nwa = 0;
    load(2, 2, -1, 0);
    load(2, 2, -1, 0);
    collect(1);
    check_2x2("nogap");
    nwa = 0;
    load(2, 2, 1, 3);
    load(2, 2, 2, 3);
    collect(1);
    check_2x2("gap");

    // reset during MAC of result (0,1)
    load(2, 2, -1, 0);
    load(2, 2, -1, 0);
    for (int c = 1; c < 9; c++) tick();
    chk("mid_rd_b", bus.rd_addr_b, 1);
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_valid", bus.valid, 0);
    chk("mid_rst_acc_en", bus.acc_en, 0);
    chk("mid_rst_acc_clr", bus.acc_clr, 0);
    chk("mid_rst_is_legal", bus.is_legal, 1);
    chk("mid_rst_crow", bus.change_row, 0);
    rst = 1'b0;
    load(1, 1, -1, 0);
    load(1, 1, -1, 0);
    collect(1);
    chk("post_nval", nval, 1);
    chk("post_vcyc", vcyc[0], 5);
    chk("post_crow", vcr[0], 1);
    chk("post_legal", vleg[0], 1);
    chk("post_done", done_cyc, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
